// File: rtl/absmax_quantizer_pkg.sv
// Shared quantization package: FSM states, code range limits and the
// saturate helper used by both the quantize and dequantize sides.
package quant_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SCALE = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int Q_MAX     = 127;
  localparam int Q_MIN     = -127;
  localparam int MAX_SHIFT = 25;
  // Width of the widened (sample + guard bit) intermediate fed to saturate.
  localparam int SAT_W     = 33;

  // Clamp a widened signed value to the symmetric 8-bit code range.
  function automatic logic signed [7:0] saturate(input logic signed [SAT_W-1:0] x);
    logic signed [7:0] y;
    if (x > 33'sd127) begin
      y = 8'sd127;
    end else if (x < -33'sd127) begin
      y = -8'sd127;
    end else begin
      y = x[7:0];
    end
    return y;
  endfunction

endpackage

// File: rtl/absmax_quantizer_if.sv
// Stream interface for absmax_quantizer: sample input channel, code output
// channel and the scale-shift side channel. Signal names follow the block's
// pin names so the suffix still tells the direction seen by the quantizer.
interface absmax_quantizer_if #(
  parameter int DIN_W   = 32,
  parameter int Q_W     = 8,
  parameter int SHIFT_W = 5
);
  logic                      din_valid_i;
  logic signed [DIN_W-1:0]   din_i;
  logic                      din_ready_o;
  logic                      q_valid_o;
  logic                      q_ready_i;
  logic signed [Q_W-1:0]     q_data_o;
  logic                      q_last_o;
  logic        [SHIFT_W-1:0] q_shift_o;

  // Quantizer side.
  modport slave (
    input  din_valid_i, din_i, q_ready_i,
    output din_ready_o, q_valid_o, q_data_o, q_last_o, q_shift_o
  );

  // Producer / consumer side.
  modport master (
    output din_valid_i, din_i, q_ready_i,
    input  din_ready_o, q_valid_o, q_data_o, q_last_o, q_shift_o
  );
endinterface

// File: rtl/absmax_shift_calc.sv
// Combinational priority encoder: smallest shift s in 0..MAX_SHIFT such that
// (max_abs >> s) fits in the positive code range.
module absmax_shift_calc
  import quant_pkg::*;
#(
  parameter int DIN_W   = 32,
  parameter int SHIFT_W = 5
) (
  input  logic [DIN_W-1:0]   i_max_abs,
  output logic [SHIFT_W-1:0] o_shift
);

  // Scan from the largest shift down so the smallest qualifying one wins.
  always_comb begin
    o_shift = SHIFT_W'(MAX_SHIFT);
    for (int s = MAX_SHIFT; s >= 0; s--) begin
      if ((i_max_abs >> s) <= DIN_W'(Q_MAX)) begin
        o_shift = SHIFT_W'(s);
      end else begin
        o_shift = o_shift;
      end
    end
  end

endmodule

// File: rtl/absmax_quantizer.sv
// absmax_quantizer: buffers one vector, finds its max-abs, derives a
// power-of-two scale shift and streams saturated signed codes.
// Optional macro QUANT_ROUND_EN: round-to-nearest instead of floor.
module absmax_quantizer
  import quant_pkg::*;
#(
  parameter int VEC_LEN = 16,
  parameter int DIN_W   = 32,
  parameter int Q_W     = 8,
  parameter int SHIFT_W = 5
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  absmax_quantizer_if.slave  bus,
  output logic               busy_o,
  output logic               done_o
);

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam logic signed [DIN_W:0] ONE_EXT = {{DIN_W{1'b0}}, 1'b1};

  logic signed [DIN_W-1:0] r_buf [VEC_LEN];
  state_e                  r_state;
  logic [CNT_W-1:0]        r_wr_cnt;
  logic [CNT_W-1:0]        r_rd_cnt;
  logic [DIN_W-1:0]        r_max_abs;
  logic                    r_din_ready;
  logic                    r_q_valid;
  logic signed [Q_W-1:0]   r_q_data;
  logic                    r_q_last;
  logic [SHIFT_W-1:0]      r_q_shift;
  logic                    r_busy;
  logic                    r_done;

  logic [DIN_W-1:0]        w_abs;
  logic                    w_accept;
  logic                    w_fire;
  logic [SHIFT_W-1:0]      w_shift;
  logic [CNT_W-1:0]        w_q_idx;
  logic [SHIFT_W-1:0]      w_q_shift;
  logic signed [Q_W-1:0]   w_q_code;

  // Shift right by sh on a widened copy (so the rounding add cannot
  // overflow), then clamp to the symmetric code range.
  function automatic logic signed [Q_W-1:0] quant(input logic signed [DIN_W-1:0] x,
                                                  input logic [SHIFT_W-1:0] sh);
    logic signed [DIN_W:0] ext;
    ext = {x[DIN_W-1], x};
`ifdef QUANT_ROUND_EN
    if (sh != '0) begin
      ext = ext + (ONE_EXT <<< (sh - 1'b1));
    end else begin
      ext = ext;
    end
`endif
    ext = ext >>> sh;
    return saturate(ext);
  endfunction

  absmax_shift_calc #(
    .DIN_W   (DIN_W),
    .SHIFT_W (SHIFT_W)
  ) u_shift_calc (
    .i_max_abs (r_max_abs),
    .o_shift   (w_shift)
  );

  // Unsigned magnitude of the incoming sample; the most negative value maps
  // to 2^(DIN_W-1) which still fits the unsigned register.
  always_comb begin
    if (bus.din_i[DIN_W-1]) begin
      w_abs = DIN_W'(-bus.din_i);
    end else begin
      w_abs = DIN_W'(bus.din_i);
    end
  end

  // Handshake qualifiers and selection of the next code to precompute:
  // buffer[0] with the fresh shift in SCALE, buffer[rd_cnt+1] in EMIT.
  always_comb begin
    w_accept = (r_state == ST_LOAD) && bus.din_valid_i;
    w_fire   = r_q_valid && bus.q_ready_i;
    if (r_state == ST_SCALE) begin
      w_q_idx   = '0;
      w_q_shift = w_shift;
    end else begin
      w_q_idx   = r_rd_cnt + CNT_W'(1);
      w_q_shift = r_q_shift;
    end
    w_q_code = quant(r_buf[w_q_idx], w_q_shift);
  end

  // Sample buffer; contents are don't-care after reset so no reset term.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_buf[r_wr_cnt] <= bus.din_i;
    end
  end

  // Main control FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= ST_IDLE;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_max_abs   <= '0;
      r_din_ready <= 1'b0;
      r_q_valid   <= 1'b0;
      r_q_data    <= '0;
      r_q_last    <= 1'b0;
      r_q_shift   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state     <= ST_LOAD;
            r_wr_cnt    <= '0;
            r_max_abs   <= '0;
            r_din_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            if (w_abs > r_max_abs) begin
              r_max_abs <= w_abs;
            end
            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            if (r_wr_cnt == CNT_W'(VEC_LEN - 1)) begin
              r_din_ready <= 1'b0;
              r_state     <= ST_SCALE;
            end
          end
        end
        ST_SCALE: begin
          r_q_shift <= w_shift;
          r_q_data  <= w_q_code;
          r_q_valid <= 1'b1;
          r_q_last  <= 1'b0;
          r_rd_cnt  <= '0;
          r_state   <= ST_EMIT;
        end
        ST_EMIT: begin
          if (w_fire) begin
            if (r_q_last) begin
              r_q_valid <= 1'b0;
              r_q_last  <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_rd_cnt <= r_rd_cnt + CNT_W'(1);
              r_q_data <= w_q_code;
              r_q_last <= (r_rd_cnt == CNT_W'(VEC_LEN - 2));
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_din_ready <= 1'b0;
          r_q_valid   <= 1'b0;
          r_q_last    <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_ready_o = r_din_ready;
  assign bus.q_valid_o   = r_q_valid;
  assign bus.q_data_o    = r_q_data;
  assign bus.q_last_o    = r_q_last;
  assign bus.q_shift_o   = r_q_shift;
  assign busy_o          = r_busy;
  assign done_o          = r_done;

endmodule

// File: tb/tb_absmax_quantizer.sv
// Directed testbench for absmax_quantizer with VEC_LEN=4.
module tb_absmax_quantizer;

  logic clk;
  logic rstn;
  logic start;
  logic busy;
  logic done;
  int   n_checks = 0;
  int   n_fail   = 0;

  absmax_quantizer_if #(.DIN_W(32), .Q_W(8), .SHIFT_W(5)) bus ();

  absmax_quantizer #(
    .VEC_LEN (4),
    .DIN_W   (32),
    .Q_W     (8),
    .SHIFT_W (5)
  ) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .start_i (start),
    .bus     (bus),
    .busy_o  (busy),
    .done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_vec(input logic [31:0] v0, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] v3, input bit gap);
    logic [31:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_load", {31'd0, busy}, 32'd1);
    chk("din_ready_load", {31'd0, bus.din_ready_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (gap && i == 2) begin
        bus.din_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("din_ready_gap", {31'd0, bus.din_ready_o}, 32'd1);
      end
      bus.din_valid_i = 1'b1;
      bus.din_i       = v[i];
      @(posedge clk); #1;
    end
    bus.din_valid_i = 1'b0;
    chk("din_ready_drop", {31'd0, bus.din_ready_o}, 32'd0);
    chk("q_valid_scale", {31'd0, bus.q_valid_o}, 32'd0);
  endtask

  task automatic recv_vec(input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3, input logic [4:0] sh);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    bus.q_ready_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("q_valid", {31'd0, bus.q_valid_o}, 32'd1);
      chk("q_data", {24'd0, bus.q_data_o}, {24'd0, e[i]});
      chk("q_last", {31'd0, bus.q_last_o}, (i == 3) ? 32'd1 : 32'd0);
      chk("q_shift", {27'd0, bus.q_shift_o}, {27'd0, sh});
      chk("done_early", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("q_valid_done", {31'd0, bus.q_valid_o}, 32'd0);
    @(posedge clk); #1;
    chk("done_clear", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("q_shift_hold", {27'd0, bus.q_shift_o}, {27'd0, sh});
  endtask

  task automatic recv_bp(input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3, input logic [4:0] sh);
    logic [7:0] e [4];
    logic [3:0] pat;
    logic [7:0] prev_d;
    logic       prev_l;
    logic       held;
    int         beat;
    int         cyc;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    pat  = 4'b1001;
    held = 1'b0;
    beat = 0;
    cyc  = 0;
    prev_d = 8'd0;
    prev_l = 1'b0;
    while (beat < 4 && cyc < 40) begin
      bus.q_ready_i = pat[cyc % 4];
      start = (cyc == 2) ? 1'b1 : 1'b0;
      if (bus.q_valid_o) begin
        if (held) begin
          chk("bp_data_stable", {24'd0, bus.q_data_o}, {24'd0, prev_d});
          chk("bp_last_stable", {31'd0, bus.q_last_o}, {31'd0, prev_l});
        end
        chk("bp_shift", {27'd0, bus.q_shift_o}, {27'd0, sh});
        if (bus.q_ready_i) begin
          chk("bp_data", {24'd0, bus.q_data_o}, {24'd0, e[beat]});
          chk("bp_last", {31'd0, bus.q_last_o}, (beat == 3) ? 32'd1 : 32'd0);
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1;
        end
        prev_d = bus.q_data_o;
        prev_l = bus.q_last_o;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    bus.q_ready_i = 1'b1;
    chk("bp_beats", beat, 32'd4);
    chk("bp_done_pulse", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("bp_busy_idle", {31'd0, busy}, 32'd0);
    chk("bp_no_restart", {31'd0, bus.din_ready_o}, 32'd0);
  endtask

  initial begin
    rstn            = 1'b0;
    start           = 1'b0;
    bus.din_valid_i = 1'b0;
    bus.din_i       = 32'd0;
    bus.q_ready_i   = 1'b1;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_din_ready", {31'd0, bus.din_ready_o}, 32'd0);
    chk("rst_q_valid", {31'd0, bus.q_valid_o}, 32'd0);
    chk("rst_q_data", {24'd0, bus.q_data_o}, 32'd0);
    chk("rst_q_last", {31'd0, bus.q_last_o}, 32'd0);
    chk("rst_q_shift", {27'd0, bus.q_shift_o}, 32'd0);
    #20;
    rstn = 1'b1;

    // Small values: shift 0, codes pass through.
    send_vec(32'd100, -32'sd50, 32'd3, 32'd0, 1'b0);
    recv_vec(8'd100, -8'sd50, 8'd3, 8'd0, 5'd3 - 5'd3);

    // max 1000 -> shift 3; input gap exercised.
    send_vec(32'd1000, -32'sd1000, 32'd5, 32'd6, 1'b1);
`ifdef QUANT_ROUND_EN
    recv_vec(8'd125, -8'sd125, 8'd1, 8'd1, 5'd3);
`else
    recv_vec(8'd125, -8'sd125, 8'd0, 8'd0, 5'd3);
`endif

    // max 255 -> shift 1; rounded 128 saturates to 127, floor gives 127.
    send_vec(32'd255, 32'd0, 32'd0, 32'd0, 1'b0);
    recv_vec(8'd127, 8'd0, 8'd0, 8'd0, 5'd1);

    // Most negative input -> shift 25, code -64.
    send_vec(32'h8000_0000, 32'd0, 32'd0, 32'd0, 1'b0);
    recv_vec(-8'sd64, 8'd0, 8'd0, 8'd0, 5'd25);

    // Backpressure with start pulsed during EMIT.
    send_vec(-32'sd300, 32'd77, 32'd1000, -32'sd7, 1'b0);
`ifdef QUANT_ROUND_EN
    recv_bp(-8'sd37, 8'd10, 8'd125, -8'sd1, 5'd3);
`else
    recv_bp(-8'sd38, 8'd9, 8'd125, -8'sd1, 5'd3);
`endif

    // Reset in the middle of EMIT after two accepted beats.
    send_vec(32'd1000, -32'sd1000, 32'd5, 32'd6, 1'b0);
    bus.q_ready_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_q_valid", {31'd0, bus.q_valid_o}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_q_valid", {31'd0, bus.q_valid_o}, 32'd0);
    chk("mid_rst_q_data", {24'd0, bus.q_data_o}, 32'd0);
    chk("mid_rst_q_shift", {27'd0, bus.q_shift_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    #10;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", {31'd0, done}, 32'd0);

    // Next vector after reset is processed normally.
    send_vec(32'd100, -32'sd50, 32'd3, 32'd0, 1'b0);
    recv_vec(8'd100, -8'sd50, 8'd3, 8'd0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
